// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the streaming KxK convolver.
// States, pipeline depth, result saturation and frame configuration checks.
package conv_pkg;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DRAIN,
      DONE
   } conv_state_e;

   localparam int PIPE_LAT = 2;

   // Floor-shift the wide sum back to Q format, then clamp to data_w bits.
   function automatic logic signed [63:0] sat_trunc(
      input logic signed [63:0] sum,
      input int                 data_w,
      input int                 frac_w
   );
      logic signed [63:0] shr;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      shr = sum >>> frac_w;
      hi  = (64'sd1 <<< (data_w - 1)) - 64'sd1;
      lo  = -(64'sd1 <<< (data_w - 1));
      if (shr > hi) begin
         sat_trunc = hi;
      end else if (shr < lo) begin
         sat_trunc = lo;
      end else begin
         sat_trunc = shr;
      end
   endfunction

   // Frame geometry must hold at least one window and fit the buffers.
   function automatic logic cfg_ok(
      input int rows,
      input int cols,
      input int stride,
      input int ksize,
      input int max_rows,
      input int max_cols
   );
      cfg_ok = (rows >= ksize) && (cols >= ksize) &&
               (rows <= max_rows) && (cols <= max_cols) &&
               ((stride == 1) || (stride == 2));
   endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// KSIZE-1 circular line stores indexed by input column.
// tap 0 is the oldest buffered row; tap KSIZE-1 is the live pixel.
module conv_line_buffer
   import conv_pkg::*;
#(
   parameter  int DATA_W   = 16,
   parameter  int KSIZE    = 3,
   parameter  int MAX_COLS = 16,
   localparam int COL_W    = $clog2(MAX_COLS)
) (
   input  logic                           clk,
   input  logic                           shift_en,
   input  logic [COL_W-1:0]               col,
   input  logic [DATA_W-1:0]              din,
   output logic [KSIZE-1:0][DATA_W-1:0]   taps
);

   logic [DATA_W-1:0] mem_q [KSIZE-1][MAX_COLS];

   // Contents are never reset; the window gating hides stale rows.
   always_ff @(posedge clk) begin
      if (shift_en) begin
         for (int j = 0; j < KSIZE - 2; j++) begin
            mem_q[j][col] <= mem_q[j+1][col];
         end
         mem_q[KSIZE-2][col] <= din;
      end
   end

   // Present the column of vertically aligned pixels for this column.
   always_comb begin
      for (int j = 0; j < KSIZE - 1; j++) begin
         taps[j] = mem_q[j][col];
      end
      taps[KSIZE-1] = din;
   end

endmodule

// File: rtl/conv_kxk_stream.sv
// Streaming KxK saturated fixed-point convolver, stride 1 or 2.
// Define CONV_RELU_EN to clamp negative results to zero (fused ReLU).
module conv_kxk_stream
   import conv_pkg::*;
#(
   parameter  int DATA_W   = 16,
   parameter  int FRAC_W   = 8,
   parameter  int KSIZE    = 3,
   parameter  int MAX_COLS = 16,
   parameter  int MAX_ROWS = 16,
   localparam int DIM_W    =
      $clog2(MAX_ROWS > MAX_COLS ? MAX_ROWS : MAX_COLS) + 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [DIM_W-1:0]              cfg_rows,
   input  logic [DIM_W-1:0]              cfg_cols,
   input  logic [1:0]                    cfg_stride,
   input  logic [KSIZE*KSIZE*DATA_W-1:0] kernel,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [DATA_W-1:0]             s_data,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [DATA_W-1:0]             m_data,
   output logic                          m_last,
   output logic                          busy,
   output logic                          done,
   output logic                          err
);

   localparam int KK     = KSIZE * KSIZE;
   localparam int PROD_W = 2 * DATA_W;
   localparam int SUM_W  = PROD_W + $clog2(KK);
   localparam int COL_W  = $clog2(MAX_COLS);
   localparam logic [DIM_W-1:0] KM1 = DIM_W'(KSIZE - 1);
   localparam logic [DIM_W-1:0] KS  = DIM_W'(KSIZE);
   localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

   conv_state_e state_q, state_d;
   logic [DIM_W-1:0]    rows_q, rows_d;
   logic [DIM_W-1:0]    cols_q, cols_d;
   logic [1:0]          stride_q, stride_d;
   logic [KK*DATA_W-1:0] kernel_q, kernel_d;
   logic [DIM_W-1:0]    in_row_q, in_row_d;
   logic [DIM_W-1:0]    in_col_q, in_col_d;
   logic                final_q, final_d;
   logic                err_q, err_d;

   logic [KSIZE-1:0][KSIZE-1:0][DATA_W-1:0] win_q, win_d;
   logic                issue_q, issue_d;
   logic                ilast_q, ilast_d;
   logic signed [PROD_W-1:0] prod_q [KK];
   logic signed [PROD_W-1:0] prod_d [KK];
   logic [PIPE_LAT-1:0] vld_q, vld_d;
   logic [PIPE_LAT-1:0] lst_q, lst_d;
   logic [DATA_W-1:0]   m_data_q, m_data_d;

   logic [KSIZE-1:0][DATA_W-1:0] taps;
   logic                pipe_en;
   logic                accept;
   logic                out_hs;
   logic                fin_hs;
   logic                last_px;
   logic                row_hit;
   logic                col_hit;
   logic                win_hit;
   logic                win_last;
   logic [DIM_W-1:0]    row_span;
   logic [DIM_W-1:0]    col_span;
   logic [DIM_W-1:0]    last_wr;
   logic [DIM_W-1:0]    last_wc;
   logic signed [SUM_W-1:0] sum;
   logic [DATA_W-1:0]   res;

   assign pipe_en = !vld_q[PIPE_LAT-1] || m_ready;
   assign s_ready = (state_q == STREAM) && pipe_en;
   assign accept  = s_valid && s_ready;
   assign out_hs  = vld_q[PIPE_LAT-1] && m_ready;
   assign fin_hs  = out_hs && lst_q[PIPE_LAT-1];
   assign m_valid = vld_q[PIPE_LAT-1];
   assign m_last  = lst_q[PIPE_LAT-1];
   assign m_data  = m_data_q;
   assign busy    = (state_q == STREAM) || (state_q == DRAIN);
   assign done    = (state_q == DONE);
   assign err     = err_q;

   conv_line_buffer #(
      .DATA_W   (DATA_W),
      .KSIZE    (KSIZE),
      .MAX_COLS (MAX_COLS)
   ) u_lb (
      .clk      (clk),
      .shift_en (accept),
      .col      (in_col_q[COL_W-1:0]),
      .din      (s_data),
      .taps     (taps)
   );

   // Window placement: which accepted pixel completes a window, and the last.
   always_comb begin
      row_span = rows_q - KS;
      col_span = cols_q - KS;
      last_wr  = KM1 + ((stride_q == 2'd2) ?
                 {row_span[DIM_W-1:1], 1'b0} : row_span);
      last_wc  = KM1 + ((stride_q == 2'd2) ?
                 {col_span[DIM_W-1:1], 1'b0} : col_span);
      row_hit  = (in_row_q >= KM1) &&
                 ((stride_q == 2'd1) || !(in_row_q[0] ^ KM1[0]));
      col_hit  = (in_col_q >= KM1) &&
                 ((stride_q == 2'd1) || !(in_col_q[0] ^ KM1[0]));
      win_hit  = accept && row_hit && col_hit;
      win_last = win_hit && (in_row_q == last_wr) && (in_col_q == last_wc);
      last_px  = (in_row_q == rows_q - ONE) && (in_col_q == cols_q - ONE);
   end

   // Frame control: config latch, raster counters and end-of-frame tracking.
   always_comb begin
      state_d  = state_q;
      rows_d   = rows_q;
      cols_d   = cols_q;
      stride_d = stride_q;
      kernel_d = kernel_q;
      in_row_d = in_row_q;
      in_col_d = in_col_q;
      final_d  = final_q;
      err_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (cfg_ok(int'(cfg_rows), int'(cfg_cols), int'(cfg_stride),
                          KSIZE, MAX_ROWS, MAX_COLS)) begin
                  rows_d   = cfg_rows;
                  cols_d   = cfg_cols;
                  stride_d = cfg_stride;
                  kernel_d = kernel;
                  in_row_d = '0;
                  in_col_d = '0;
                  final_d  = 1'b0;
                  state_d  = STREAM;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         STREAM: begin
            if (fin_hs) begin
               final_d = 1'b1;
            end
            if (accept) begin
               if (in_col_q == cols_q - ONE) begin
                  in_col_d = '0;
                  in_row_d = in_row_q + ONE;
               end else begin
                  in_col_d = in_col_q + ONE;
               end
               if (last_px) begin
                  state_d = (final_q || fin_hs) ? DONE : DRAIN;
               end
            end
         end
         DRAIN: begin
            if (fin_hs) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath: window shift, product stage, saturated sum stage.
   always_comb begin
      win_d    = win_q;
      issue_d  = issue_q;
      ilast_d  = ilast_q;
      vld_d    = vld_q;
      lst_d    = lst_q;
      m_data_d = m_data_q;
      for (int i = 0; i < KK; i++) begin
         prod_d[i] = prod_q[i];
      end
      sum = '0;
      for (int i = 0; i < KK; i++) begin
         sum = sum + SUM_W'(prod_q[i]);
      end
      res = DATA_W'(sat_trunc(64'(sum), DATA_W, FRAC_W));
`ifdef CONV_RELU_EN
      if (res[DATA_W-1]) begin
         res = '0;
      end
`else
      res = res;
`endif
      if (accept) begin
         for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE - 1; c++) begin
               win_d[r][c] = win_q[r][c+1];
            end
            win_d[r][KSIZE-1] = taps[r];
         end
      end
      if (pipe_en) begin
         issue_d = win_hit;
         ilast_d = win_last;
         for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE; c++) begin
               prod_d[r*KSIZE+c] =
                  PROD_W'($signed(win_q[r][c])) *
                  PROD_W'($signed(kernel_q[(r*KSIZE+c)*DATA_W +: DATA_W]));
            end
         end
         vld_d = {vld_q[PIPE_LAT-2:0], issue_q};
         lst_d = {lst_q[PIPE_LAT-2:0], ilast_q};
         if (vld_q[PIPE_LAT-2]) begin
            m_data_d = res;
         end
      end
   end

   // State and control registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rows_q   <= '0;
         cols_q   <= '0;
         stride_q <= '0;
         kernel_q <= '0;
         in_row_q <= '0;
         in_col_q <= '0;
         final_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rows_q   <= rows_d;
         cols_q   <= cols_d;
         stride_q <= stride_d;
         kernel_q <= kernel_d;
         in_row_q <= in_row_d;
         in_col_q <= in_col_d;
         final_q  <= final_d;
         err_q    <= err_d;
      end
   end

   // Window and pipeline registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q    <= '0;
         issue_q  <= 1'b0;
         ilast_q  <= 1'b0;
         vld_q    <= '0;
         lst_q    <= '0;
         m_data_q <= '0;
         for (int i = 0; i < KK; i++) begin
            prod_q[i] <= '0;
         end
      end else begin
         win_q    <= win_d;
         issue_q  <= issue_d;
         ilast_q  <= ilast_d;
         vld_q    <= vld_d;
         lst_q    <= lst_d;
         m_data_q <= m_data_d;
         for (int i = 0; i < KK; i++) begin
            prod_q[i] <= prod_d[i];
         end
      end
   end

endmodule
